hilo_muldiv_unit: RTL and testbench

- Iterative multiply/divide unit in the EX stage, alongside the 32-bit ALU.
- Takes the same forwarded rs/rt operands and executes MULT, MULTU, DIV and DIVU over multiple cycles.
- Holds the architectural HI/LO registers that MFHI/MFLO read and MTHI/MTLO write.
- Busy drives the hazard unit, which stalls IF/ID/EX while Busy=1.

---
 rtl/hilo_muldiv_unit.sv | 155 +++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// Optional macro MULDIV_FLUSH_EN adds a Flush input that aborts an operation in flight.
module hilo_muldiv_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Start,
  input  logic [1:0]            Op,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  HiWrite,
  input  logic                  LoWrite,
`ifdef MULDIV_FLUSH_EN
  input  logic                  Flush,
`endif
  output logic                  Busy,
  output logic                  Done,
  output logic                  DivByZero,
  output logic [DATA_WIDTH-1:0] Hi,
  output logic [DATA_WIDTH-1:0] Lo
);

  localparam int W = DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]           state;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 is_div;
  logic                 neg_a;
  logic                 neg_b;
  logic                 div_zero;
  logic [W-1:0]         opnd;     // multiplicand or divisor magnitude
  logic [W-1:0]         work_hi;  // product high half or partial remainder
  logic [W-1:0]         work_lo;  // multiplier/product low half or dividend/quotient

  logic flush;
`ifdef MULDIV_FLUSH_EN
  assign flush = Flush;
`else
  assign flush = 1'b0;
`endif

  // Operand capture: signed ops (Op[0]=0) work on magnitudes.
  logic         a_neg_in, b_neg_in;
  logic [W-1:0] a_abs, b_abs;
  assign a_neg_in = ~Op[0] & A[W-1];
  assign b_neg_in = ~Op[0] & B[W-1];
  assign a_abs    = a_neg_in ? -A : A;
  assign b_abs    = b_neg_in ? -B : B;

  // One shift-add multiply step: add into the high half, shift right by one.
  logic [W:0] mul_sum;
  assign mul_sum = {1'b0, work_hi} + {1'b0, (work_lo[0] ? opnd : {W{1'b0}})};

  // One restoring divide step: shift in the next dividend bit, subtract if it fits.
  logic [W:0]   div_shift;
  logic         div_ge;
  logic [W-1:0] rem_next;
  assign div_shift = {work_hi, work_lo[W-1]};
  assign div_ge    = div_shift >= {1'b0, opnd};
  assign rem_next  = div_shift[W-1:0] - (div_ge ? opnd : {W{1'b0}});

  // Sign correction applied in FIX.
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix, rem_fix;
  assign prod_fix = (neg_a ^ neg_b) ? -{work_hi, work_lo} : {work_hi, work_lo};
  assign quo_fix  = div_zero ? {W{1'b1}} : ((neg_a ^ neg_b) ? -work_lo : work_lo);
  assign rem_fix  = neg_a ? -work_hi : work_hi;

  // NOTE: all state here updates with <= so every branch reads pre-edge values.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      is_div    <= 1'b0;
      neg_a     <= 1'b0;
      neg_b     <= 1'b0;
      div_zero  <= 1'b0;
      opnd      <= '0;
      work_hi   <= '0;
      work_lo   <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
      Hi        <= '0;
      Lo        <= '0;
    end else begin
      Done      <= 1'b0;
      DivByZero <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Start && !flush) begin
            is_div   <= Op[1];
            neg_a    <= a_neg_in;
            neg_b    <= b_neg_in;
            div_zero <= Op[1] && (B == '0);
            opnd     <= Op[1] ? b_abs : a_abs;
            work_hi  <= '0;
            work_lo  <= Op[1] ? a_abs : b_abs;
            cnt      <= '0;
            Busy     <= 1'b1;
            state    <= ST_RUN;
          end else if (!Start) begin
            if (HiWrite) Hi <= A;
            if (LoWrite) Lo <= A;
          end
        end
        ST_RUN: begin
          if (flush) begin
            Busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            if (is_div) begin
              work_hi <= rem_next;
              work_lo <= {work_lo[W-2:0], div_ge};
            end else begin
              work_hi <= mul_sum[W:1];
              work_lo <= {mul_sum[0], work_lo[W-1:1]};
            end
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              cnt   <= '0;
              state <= ST_FIX;
            end
          end
        end
        ST_FIX: begin
          if (flush) begin
            Busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            Hi    <= is_div ? rem_fix : prod_fix[2*W-1:W];
            Lo    <= is_div ? quo_fix : prod_fix[W-1:0];
            state <= ST_DONE;
          end
        end
        default: begin
          // Done and Busy=0 appear together; the unit is IDLE again that cycle.
          Busy      <= 1'b0;
          Done      <= 1'b1;
          DivByZero <= div_zero;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: directed MULT/DIV vectors, MTHI/MTLO, reset and flush.
module tb_hilo_muldiv_unit;

  logic        Clk;
  logic        Rst;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] A, B;
  logic        HiWrite, LoWrite;
  logic        Busy, Done, DivByZero;
  logic [31:0] Hi, Lo;
`ifdef MULDIV_FLUSH_EN
  logic        Flush;
`endif

  hilo_muldiv_unit dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Start     (Start),
    .Op        (Op),
    .A         (A),
    .B         (B),
    .HiWrite   (HiWrite),
    .LoWrite   (LoWrite),
`ifdef MULDIV_FLUSH_EN
    .Flush     (Flush),
`endif
    .Busy      (Busy),
    .Done      (Done),
    .DivByZero (DivByZero),
    .Hi        (Hi),
    .Lo        (Lo)
  );

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   done_cnt = 0;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every Done pulse is matched against the oldest expected result.
  always @(negedge Clk) begin
    if (!Rst && Done === 1'b1) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check({e.name, "_hi"}, Hi, e.hi);
        check({e.name, "_lo"}, Lo, e.lo);
        check({e.name, "_dbz"}, DivByZero, e.dbz);
        check({e.name, "_cycle"}, cyc, e.cyc);
      end
    end
  end

  // Called at a negedge. Start is driven with HiWrite/LoWrite (Start must win),
  // operands are scrambled after launch, and optionally Start/HiWrite are pulsed mid-op.
  task automatic issue(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                       input logic dbz, input bit disturb);
    logic [31:0] hi0, lo0;
    int busy_cnt;
    hi0 = Hi;
    lo0 = Lo;
    Start = 1'b1; Op = op; A = a; B = b; HiWrite = 1'b1; LoWrite = 1'b1;
    sb.push_back('{name, hi, lo, dbz, cyc + 1 + 34});
    @(negedge Clk);
    Start = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0;
    A = $urandom; B = $urandom;
    check({name, "_hi_held"}, Hi, hi0);
    check({name, "_lo_held"}, Lo, lo0);
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (Done === 1'b1) break;
      if (Busy === 1'b1) busy_cnt++;
      if (disturb && i == 5) begin
        Start = 1'b1; HiWrite = 1'b1; Op = OP_DIVU; A = 32'hDEAD_BEEF;
      end else if (disturb && i == 6) begin
        Start = 1'b0; HiWrite = 1'b0;
      end
      @(negedge Clk);
    end
    check({name, "_done_seen"}, Done, 1'b1);
    check({name, "_busy_cycles"}, busy_cnt, 34);
    check({name, "_busy_low_at_done"}, Busy, 1'b0);
  endtask

  initial begin
    int saved;
    Rst = 1'b1; Start = 1'b0; Op = 2'b00; A = '0; B = '0; HiWrite = 1'b0; LoWrite = 1'b0;
`ifdef MULDIV_FLUSH_EN
    Flush = 1'b0;
`endif
    repeat (3) @(negedge Clk);
    check("rst_hi", Hi, 32'h0);
    check("rst_lo", Lo, 32'h0);
    check("rst_busy", Busy, 1'b0);
    check("rst_done", Done, 1'b0);
    check("rst_dbz", DivByZero, 1'b0);
    Rst = 1'b0;
    @(negedge Clk);

    issue("mult_neg3x7",   OP_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0);
    issue("multu_max",     OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);
    issue("div_neg7_2",    OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
    issue("divu_100_7",    OP_DIVU,  32'd100,       32'd7,        32'd2,         32'd14,        1'b0, 1'b0);
    issue("div_by_zero",   OP_DIV,   32'h1234_5678, 32'd0,        32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 1'b0);
    issue("div_ovf",       OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000, 1'b0, 1'b0);
    issue("divu_by_zero",  OP_DIVU,  32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF, 1'b1, 1'b0);
    issue("div_7_neg2",    OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 1'b0, 1'b0);
    issue("div_neg8_neg3", OP_DIV,   32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'd2,        1'b0, 1'b0);
    issue("mult_min_min",  OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,        1'b0, 1'b0);
    issue("mult_disturb",  OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,        32'h1,         1'b0, 1'b1);

    // MTHI / MTLO in IDLE.
    @(negedge Clk);
    HiWrite = 1'b1; A = 32'hAAAA_5555;
    @(negedge Clk);
    HiWrite = 1'b0;
    check("mthi_hi", Hi, 32'hAAAA_5555);
    check("mthi_lo_kept", Lo, 32'h1);
    HiWrite = 1'b1; LoWrite = 1'b1; A = 32'h0BAD_F00D;
    @(negedge Clk);
    HiWrite = 1'b0; LoWrite = 1'b0;
    check("mthilo_hi", Hi, 32'h0BAD_F00D);
    check("mthilo_lo", Lo, 32'h0BAD_F00D);

    // Reset at cycle 10 of a MULT discards it.
    Start = 1'b1; Op = OP_MULTU; A = 32'd9; B = 32'd9;
    @(negedge Clk);
    Start = 1'b0;
    repeat (9) @(negedge Clk);
    saved = done_cnt;
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    check("midrst_hi", Hi, 32'h0);
    check("midrst_lo", Lo, 32'h0);
    check("midrst_busy", Busy, 1'b0);
    check("midrst_done", Done, 1'b0);
    repeat (40) @(negedge Clk);
    check("midrst_no_done", done_cnt, saved);

`ifdef MULDIV_FLUSH_EN
    LoWrite = 1'b1; A = 32'h11;
    @(negedge Clk);
    LoWrite = 1'b0;
    Start = 1'b1; Op = OP_MULT; A = 32'd5; B = 32'd5;
    @(negedge Clk);
    Start = 1'b0;
    repeat (4) @(negedge Clk);
    saved = done_cnt;
    Flush = 1'b1;
    @(negedge Clk);
    Flush = 1'b0;
    check("flush_busy", Busy, 1'b0);
    check("flush_lo", Lo, 32'h11);
    issue("mult_after_flush", OP_MULT, 32'd5, 32'd5, 32'h0, 32'd25, 1'b0, 1'b0);
    check("flush_no_extra_done", done_cnt, saved + 1);
`endif

    repeat (3) @(negedge Clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
